// File: rtl/aoc_day01_ascii_loader.sv
// aoc_day01_ascii_loader: parses "<left><ws><right>\n" ASCII lines into an interleaved word memory (left at 2k, right at 2k+1).
// Define AOC_COL_SUM_EN to add per-column wrapping checksums sum_left/sum_right.
module aoc_day01_ascii_loader #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 2000,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] pair_count,
`ifdef AOC_COL_SUM_EN
    output logic [WORD_W-1:0] sum_left,
    output logic [WORD_W-1:0] sum_right,
`endif
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {GAP, NUM, DONE, ERR} state_t;
    state_t            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              col_q, col_d;
    logic              full_q, full_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] pair_q, pair_d;
    logic              emit, bad;
    logic [WORD_W-1:0] emit_val;
    logic              is_digit, is_ws, is_eol, is_cr, mem_full;
    logic [WORD_W-1:0] digit, acc_mac;
    assign is_digit = in_data >= 8'h30 && in_data <= 8'h39;
    assign is_ws    = in_data == 8'h20 || in_data == 8'h09;
    assign is_eol   = in_data == 8'h0A;
    assign is_cr    = in_data == 8'h0D;
    assign digit    = {{(WORD_W-4){1'b0}}, in_data[3:0]};
    assign acc_mac  = acc_q * WORD_W'(10) + digit;
    // addr counts one past ADDR_W so a completely full memory is distinguishable from empty
    assign mem_full = addr_q == (ADDR_W+1)'(DEPTH);
    assign in_ready   = state_q == GAP || state_q == NUM;
    assign done       = state_q == DONE;
    assign err        = state_q == ERR;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign pair_count = pair_q;
    // Byte parser: col=1 means the right value is next; full marks a line whose right value already ended on whitespace
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        col_d    = col_q;
        full_d   = full_q;
        emit     = 1'b0;
        emit_val = acc_q;
        bad      = 1'b0;
        if (in_valid && in_ready) begin
            case (state_q)
                GAP: begin
                    if (is_digit) begin
                        bad     = full_q || mem_full;
                        acc_d   = digit;
                        state_d = NUM;
                    end else if (is_eol) begin
                        bad    = col_q;
                        full_d = 1'b0;
                    end else begin
                        bad = !(is_ws || is_cr);
                    end
                end
                NUM: begin
                    if (is_digit) begin
                        acc_d = acc_mac;
                    end else if (is_ws || is_eol) begin
                        bad     = is_eol && !col_q;
                        emit    = !bad;
                        col_d   = !col_q;
                        full_d  = is_ws && col_q;
                        state_d = GAP;
                    end else begin
                        bad = !is_cr;
                    end
                end
                default: ;
            endcase
            if (bad) begin
                state_d = ERR;
            end else if (in_last) begin
                if (state_d == NUM) begin
                    emit     = 1'b1;
                    emit_val = acc_d;
                    col_d    = !col_q;
                end
                state_d = col_d ? ERR : DONE;
            end
        end
        addr_d    = emit ? addr_q + (ADDR_W+1)'(1) : addr_q;
        wr_en_d   = emit;
        wr_addr_d = emit ? addr_q[ADDR_W-1:0] : wr_addr_q;
        wr_data_d = emit ? emit_val : wr_data_q;
        pair_d    = pair_q + ADDR_W'(emit && addr_q[0]);
    end
    // Parser state and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= GAP;
            acc_q     <= '0;
            addr_q    <= '0;
            col_q     <= 1'b0;
            full_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pair_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            addr_q    <= addr_d;
            col_q     <= col_d;
            full_q    <= full_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pair_q    <= pair_d;
        end
    end
`ifdef AOC_COL_SUM_EN
    logic [WORD_W-1:0] sum_left_q, sum_left_d, sum_right_q, sum_right_d;
    assign sum_left  = sum_left_q;
    assign sum_right = sum_right_q;
    // Column checksums follow the write strobe of their column
    always_comb begin
        sum_left_d  = sum_left_q + ((emit && !addr_q[0]) ? emit_val : '0);
        sum_right_d = sum_right_q + ((emit && addr_q[0]) ? emit_val : '0);
    end
    // Checksum registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_left_q  <= '0;
            sum_right_q <= '0;
        end else begin
            sum_left_q  <= sum_left_d;
            sum_right_q <= sum_right_d;
        end
    end
`endif
endmodule
